// File: rtl/register_file_mp_if.sv
// Bus between decode/writeback (master) and the multi-port register file (slave).
// Every request is qualified by its own enable (wr_en, reserve_en); there is no back-pressure.
interface register_file_mp_if #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int AW           = $clog2(NUM_REGS)
);
  logic [NUM_RD_PORTS-1:0][AW-1:0]   rd_reg;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD_PORTS-1:0]           rd_busy;
  logic [NUM_WR_PORTS-1:0]           wr_en;
  logic [NUM_WR_PORTS-1:0][AW-1:0]   wr_reg;
  logic [NUM_WR_PORTS-1:0][XLEN-1:0] wr_data;
  logic                              reserve_en;
  logic [AW-1:0]                     reserve_reg;
  logic                              wr_conflict;

  modport master (
    output rd_reg, wr_en, wr_reg, wr_data, reserve_en, reserve_reg,
    input  rd_data, rd_busy, wr_conflict
  );

  modport slave (
    input  rd_reg, wr_en, wr_reg, wr_data, reserve_en, reserve_reg,
    output rd_data, rd_busy, wr_conflict
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a busy scoreboard.
// Register 0 has no storage: it reads as zero and is never busy.
module register_file_mp #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int BYPASS       = 0,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);

  logic [XLEN-1:0]     regs    [1:NUM_REGS-1];
  logic [XLEN-1:0]     wr_next [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] busy;
  logic [NUM_REGS-1:1] wr_hit;
  logic                collision;
  logic                wr_conflict_q;

  // Ports are scanned in ascending order so the highest-index writer wins.
  always_comb begin
    wr_hit = '0;
    for (int r = 1; r < NUM_REGS; r++) wr_next[r] = '0;
    for (int w = 0; w < NUM_WR_PORTS; w++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (bus.wr_en[w] && bus.wr_reg[w] == AW'(r)) begin
          wr_hit[r]  = 1'b1;
          wr_next[r] = bus.wr_data[w];
        end
      end
    end
  end

  always_comb begin
    collision = 1'b0;
    for (int i = 0; i < NUM_WR_PORTS; i++) begin
      for (int j = i + 1; j < NUM_WR_PORTS; j++) begin
        if (bus.wr_en[i] && bus.wr_en[j] && bus.wr_reg[i] == bus.wr_reg[j] &&
            bus.wr_reg[i] != '0)
          collision = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NUM_REGS; r++) regs[r] <= '0;
      busy          <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_next[r];
        // A reservation is a new producer, so it overrides the clear from a retiring write.
        if (bus.reserve_en && bus.reserve_reg == AW'(r)) busy[r] <= 1'b1;
        else if (wr_hit[r])                               busy[r] <= 1'b0;
      end
      wr_conflict_q <= collision;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (bus.rd_reg[p] == AW'(r)) begin
          bus.rd_data[p] = regs[r];
          bus.rd_busy[p] = busy[r];
        end
      end
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
          if (bus.wr_en[w] && bus.wr_reg[w] == bus.rd_reg[p] && bus.rd_reg[p] != '0) begin
            bus.rd_data[p] = bus.wr_data[w];
            bus.rd_busy[p] = 1'b0;
          end
        end
      end
    end
  end

  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file for the RISC-V core. It generalises the 32x32, 2-read/1-write register file in three ways: configurable port counts, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for pipelined issue. It sits between decode (read ports, reserve) and writeback (write ports). Register 0 is hardwired to zero.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NUM_REGS, 32, register count; power of two, ≥ 2
- NUM_RD_PORTS, 2, read ports; 1–4
- NUM_WR_PORTS, 1, write ports; 1–2
- BYPASS, 0, 1 = same-cycle write data forwarded to reads; 0 = reads return pre-write value
- AW, $clog2(NUM_REGS), register index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_reg  in  [NUM_RD_PORTS][AW]  read register index per port
- rd_data  out  [NUM_RD_PORTS][XLEN]  read data per port, combinational
- rd_busy  out  [NUM_RD_PORTS]  scoreboard busy bit of rd_reg, combinational
- wr_en  in  [NUM_WR_PORTS]  write enable per port
- wr_reg  in  [NUM_WR_PORTS][AW]  write register index per port
- wr_data  in  [NUM_WR_PORTS][XLEN]  write data per port
- reserve_en  in  1  mark reserve_reg busy
- reserve_reg  in  AW  register to reserve
- wr_conflict  out  1  registered; pulses when ≥ 2 write ports hit one register in the previous cycle

## Operation
- Storage: registers 1..NUM_REGS-1. Register 0 is not stored; it always reads 0 and has busy 0.
- Write: on posedge, for each port i with wr_en[i]=1 and wr_reg[i]≠0, the register takes wr_data[i]. Writes to register 0 are dropped silently.
- Write collision: when two enabled ports target the same nonzero register, the higher port index wins. wr_conflict=1 in the following cycle only. A collision on register 0 does not raise wr_conflict.
- Read, BYPASS=0: rd_data[p] is the stored value of rd_reg[p]. Same-cycle writes are not visible until after the edge. This matches the previous generation.
- Read, BYPASS=1: if any enabled port writes rd_reg[p]≠0 this cycle, rd_data[p] is that port's wr_data. The highest index wins. Otherwise it is the stored value.
- Scoreboard: one busy bit per register.
  - reserve_en=1 and reserve_reg≠0 sets busy at posedge.
  - Any accepted write to a register clears its busy bit at posedge.
  - Reserve and write to the same register in one cycle: reserve wins and busy stays 1. This models a new producer.
  - Reserve of register 0 is ignored.
- rd_busy[p] is the busy bit of rd_reg[p]. With BYPASS=1 it is forced to 0 when an enabled write to rd_reg[p] is present this cycle.
- Any read port may address any register, including both ports addressing the same register.

## Timing
- Reset (async assert, any time including mid-write): all registers 0, all busy bits 0, wr_conflict 0. Outputs take these values immediately, without waiting for a clock.
- Release: the first state update happens on the first posedge after rst deasserts.
- Write latency: 1 cycle. With BYPASS=1, read-after-write latency is 0 cycles.
- Reserve latency: 1 cycle. rd_busy goes high the cycle after reserve_en.
- wr_conflict: 1-cycle registered pulse. Back-to-back collisions keep it high.
- Inputs are sampled at posedge and must be stable 2 ns before the edge. The bench drives inputs just after posedge and samples outputs 3 ns later.

## Test plan
- Reset, then read all registers on every port → rd_data=0 and rd_busy=0. Assert rst mid-run after writing x5=0xDEADBEEF → x5 reads 0 immediately.
- Write x0=0xFFFFFFFF, then read x0 on all ports → 0. No wr_conflict, even with both write ports targeting x0.
- BYPASS=0: write x7=0x12345678 while reading x7 → old value 0 this cycle, 0x12345678 next cycle. BYPASS=1 → 0x12345678 in the same cycle.
- NUM_WR_PORTS=2: port0 writes x9=0xAAAA0000 and port1 writes x9=0x0000BBBB in the same cycle → x9=0x0000BBBB. wr_conflict=1 for exactly one cycle.
- Scoreboard:
  - Reserve x3 → rd_busy=1 next cycle.
  - Write x3 → busy clears after the edge (with BYPASS=1, rd_busy=0 already during the write cycle).
  - Reserve and write x3 in the same cycle → busy stays 1.
- 1000 random transactions per configuration (port counts 1/2/4, BYPASS 0/1) scored against a reference model. Zero mismatches required, with coverage of all write ports and all registers.
